sif_xa_arbiter: RTL

//  Shares one WA-side SIF slave port between two XA-side requesters (xa0, xa1).

---
 rtl/sif_xa_arbiter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/sif_xa_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sif_xa_arbiter
// Brief    : Round-robin arbiter that shares one WA-side SIF slave port
//            between two XA-side requesters (xa0, xa1). Each XA op
//            (WRITE/READ/IDLE/ILLEGAL) is sequenced onto the WA bus and
//            answered with a one-cycle done pulse plus err/rdata. ILLEGAL
//            requests and WA timeouts are reported as err, so a silent
//            slave can never hang a requester.
// Ports    : clk, rst              clock, synchronous active-high reset
//            xaN_wr_s / xaN_rd_s   N=0,1 request strobes, held until done
//            xaN_addr / xaN_wdata  request address / write data
//            xaN_rdata             read data, valid while xaN_done=1
//            xaN_done / xaN_err    completion pulse / error flag
//            wa_wr_s / wa_rd_s     WA write / read strobes (registered)
//            wa_addr / wa_wdata    WA address / write data (registered)
//            wa_ready / wa_rdata   WA accept / read data
//            busy / owner          FSM not idle / requester being served
// Revision : 1.0 - initial release
// ============================================================================
module sif_xa_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          xa0_wr_s,
    input  logic          xa0_rd_s,
    input  logic [AW-1:0] xa0_addr,
    input  logic [DW-1:0] xa0_wdata,
    output logic [DW-1:0] xa0_rdata,
    output logic          xa0_done,
    output logic          xa0_err,
    input  logic          xa1_wr_s,
    input  logic          xa1_rd_s,
    input  logic [AW-1:0] xa1_addr,
    input  logic [DW-1:0] xa1_wdata,
    output logic [DW-1:0] xa1_rdata,
    output logic          xa1_done,
    output logic          xa1_err,
    output logic          wa_wr_s,
    output logic          wa_rd_s,
    output logic [AW-1:0] wa_addr,
    output logic [DW-1:0] wa_wdata,
    input  logic          wa_ready,
    input  logic [DW-1:0] wa_rdata,
    output logic          busy,
    output logic          owner
);

    // Counter wide enough to hold TIMEOUT-1; kept at one bit when the
    // timeout is disabled so the declaration stays legal.
    localparam int              c_TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_TW-1:0] c_TMO_LAST = (TIMEOUT > 0) ? c_TW'(TIMEOUT - 1) : '0;
    localparam logic [c_TW-1:0] c_TMO_ONE  = c_TW'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    logic [1:0]      r_state,    w_state_nxt;
    logic            r_rr_ptr,   w_rr_ptr_nxt;
    logic            r_owner,    w_owner_nxt;
    logic            r_op_wr,    w_op_wr_nxt;
    logic            r_op_rd,    w_op_rd_nxt;
    logic [AW-1:0]   r_addr,     w_addr_nxt;
    logic [DW-1:0]   r_wdata,    w_wdata_nxt;
    logic [c_TW-1:0] r_tmo_cnt,  w_tmo_cnt_nxt;
    logic            r_err,      w_err_nxt;
    logic [DW-1:0]   r_rdata,    w_rdata_nxt;
    logic            r_wa_wr,    w_wa_wr_nxt;
    logic            r_wa_rd,    w_wa_rd_nxt;
    logic [AW-1:0]   r_wa_addr,  w_wa_addr_nxt;
    logic [DW-1:0]   r_wa_wdata, w_wa_wdata_nxt;

    logic            w_req0;
    logic            w_req1;
    logic            w_pick;
    logic            w_pick_wr;
    logic            w_pick_rd;
    logic [AW-1:0]   w_pick_addr;
    logic [DW-1:0]   w_pick_wdata;
    logic            w_tmo_hit;
    logic            w_resp;

    // ------------------------------------------------------------------
    // Request selection: a lone requester always wins; on a tie the
    // round-robin pointer decides.
    // ------------------------------------------------------------------
    always_comb begin
        w_req0       = xa0_wr_s | xa0_rd_s;
        w_req1       = xa1_wr_s | xa1_rd_s;
        w_pick       = (w_req0 & w_req1) ? r_rr_ptr : w_req1;
        w_pick_wr    = w_pick ? xa1_wr_s  : xa0_wr_s;
        w_pick_rd    = w_pick ? xa1_rd_s  : xa0_rd_s;
        w_pick_addr  = w_pick ? xa1_addr  : xa0_addr;
        w_pick_wdata = w_pick ? xa1_wdata : xa0_wdata;
        w_tmo_hit    = (TIMEOUT > 0) && (r_tmo_cnt == c_TMO_LAST);
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_owner_nxt   = r_owner;
        w_op_wr_nxt   = r_op_wr;
        w_op_rd_nxt   = r_op_rd;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_tmo_cnt_nxt = r_tmo_cnt;
        w_err_nxt     = r_err;
        w_rdata_nxt   = r_rdata;

        case (r_state)
            c_IDLE: begin
                if (w_req0 | w_req1) begin
                    w_owner_nxt   = w_pick;
                    w_op_wr_nxt   = w_pick_wr;
                    w_op_rd_nxt   = w_pick_rd;
                    w_addr_nxt    = w_pick_addr;
                    w_wdata_nxt   = w_pick_wdata;
                    w_tmo_cnt_nxt = '0;
                    w_rdata_nxt   = '0;
                    if (w_pick_wr & w_pick_rd) begin
                        // ILLEGAL: answer straight away, never touch WA
                        w_state_nxt = c_RESP;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = c_ACCESS;
                        w_err_nxt   = 1'b0;
                    end
                end
            end

            c_ACCESS: begin
                if (wa_ready) begin
                    w_state_nxt   = c_RESP;
                    w_err_nxt     = 1'b0;
                    w_rdata_nxt   = r_op_rd ? wa_rdata : '0;
                    w_tmo_cnt_nxt = '0;
                end else if (w_tmo_hit) begin
                    w_state_nxt   = c_RESP;
                    w_err_nxt     = 1'b1;
                    w_rdata_nxt   = '0;
                    w_tmo_cnt_nxt = '0;
                end else if (TIMEOUT > 0) begin
                    // Cleared on every ACCESS exit, so it cannot wrap
                    w_tmo_cnt_nxt = r_tmo_cnt + c_TMO_ONE;
                end
            end

            c_RESP: begin
                w_rr_ptr_nxt  = ~r_owner;
                w_tmo_cnt_nxt = '0;
                w_state_nxt   = c_IDLE;
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase

        // WA bus is registered and only active while the next state is
        // ACCESS with a legal op; a write strobe excludes a read strobe.
        w_wa_wr_nxt    = (w_state_nxt == c_ACCESS) & w_op_wr_nxt;
        w_wa_rd_nxt    = (w_state_nxt == c_ACCESS) & w_op_rd_nxt & ~w_op_wr_nxt;
        w_wa_addr_nxt  = (w_state_nxt == c_ACCESS) ? w_addr_nxt  : '0;
        w_wa_wdata_nxt = (w_state_nxt == c_ACCESS) ? w_wdata_nxt : '0;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_rr_ptr   <= 1'b0;
            r_owner    <= 1'b0;
            r_op_wr    <= 1'b0;
            r_op_rd    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_tmo_cnt  <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_wa_wr    <= 1'b0;
            r_wa_rd    <= 1'b0;
            r_wa_addr  <= '0;
            r_wa_wdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_op_wr    <= w_op_wr_nxt;
            r_op_rd    <= w_op_rd_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_tmo_cnt  <= w_tmo_cnt_nxt;
            r_err      <= w_err_nxt;
            r_rdata    <= w_rdata_nxt;
            r_wa_wr    <= w_wa_wr_nxt;
            r_wa_rd    <= w_wa_rd_nxt;
            r_wa_addr  <= w_wa_addr_nxt;
            r_wa_wdata <= w_wa_wdata_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: the response is steered to the owner only, the other side
    // sees all zeros.
    // ------------------------------------------------------------------
    assign w_resp    = (r_state == c_RESP);
    assign xa0_done  = w_resp & ~r_owner;
    assign xa1_done  = w_resp &  r_owner;
    assign xa0_err   = xa0_done & r_err;
    assign xa1_err   = xa1_done & r_err;
    assign xa0_rdata = xa0_done ? r_rdata : '0;
    assign xa1_rdata = xa1_done ? r_rdata : '0;
    assign wa_wr_s   = r_wa_wr;
    assign wa_rd_s   = r_wa_rd;
    assign wa_addr   = r_wa_addr;
    assign wa_wdata  = r_wa_wdata;
    assign busy      = (r_state != c_IDLE);
    assign owner     = r_owner;

endmodule
`default_nettype wire
